pipe_stage_chain: RTL and testbench
===================================

Name: pipe_stage_chain

Overview:
- Parametrised successor to the single stall/flush pipeline register.
- Chain of DEPTH register stages, each with its own valid bit, and a valid/ready handshake at both ends.
- Optional bubble-collapse mode lets upstream stages advance into empty slots while the tail is stalled.
- Used between datapath stages (e.g. issue to execute) and as a small elastic buffer in the dual-issue front end.

Parameters:
- WIDTH, 32, data bits per stage.
- DEPTH, 3, number of stages; legal range 1..8.
- COLLAPSE, 1, 1 = bubble-collapse mode, 0 = lockstep mode (whole chain advances or holds together).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- flush  in  1  clears all stages at the next edge.
- in_valid  in  1  producer has data.
- in_data  in  WIDTH  producer data.
- in_ready  out  1  chain accepts in_data this cycle.
- out_valid  out  1  last stage holds valid data.
- out_data  out  WIDTH  last stage data.
- out_ready  in  1  consumer accepts out_data this cycle.
- count  out  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Storage: stages S[0] (input side) to S[DEPTH-1] (output side), each with data d[i] and valid v[i].
- Reset: while reset==0 at a clk edge, all v[i]=0 and all d[i]=0. Therefore out_valid=0, out_data=0, count=0. in_ready is combinational and equals 1 in reset state (with flush=0).
- Reset mid-operation discards all contents; no output transfer is counted on the reset edge.
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- out_valid = v[DEPTH-1] and out_data = d[DEPTH-1], both registered, with no combinational path from in_* to out_*.
- COLLAPSE=1:
  - move[DEPTH-1] = ~v[DEPTH-1] | out_ready.
  - For i<DEPTH-1: move[i] = ~v[i+1] | move[i+1].
  - in_ready = (~v[0] | move[0]) & ~flush.
  - Stage i loads from stage i-1 (stage 0 loads from in_data/in_valid) when move[i].
  - A stage whose source is invalid becomes invalid; empty slots propagate forward as bubbles.
- COLLAPSE=0:
  - adv = ~v[DEPTH-1] | out_ready.
  - All stages shift one position when adv, otherwise all hold.
  - in_ready = adv & ~flush.
  - Identical to DEPTH cascaded stall registers with stall = ~adv.
- Data of an invalid stage is don't-care for output, but it must hold its value (no toggling) when not loaded.
- Latency: an empty, unstalled chain presents in_data on out_data DEPTH cycles after in_xfer. Throughput is 1 per cycle.
- Flush:
  - Dominates stall (unlike the old register). On a flush edge all v[i]=0 regardless of out_ready.
  - in_ready=0 while flush=1, so no input is accepted that cycle.
  - An out_xfer occurring in the same cycle as flush is still a completed transfer; the consumer owns it.
  - Data registers hold on flush.
- Reset has priority over flush.
- Full chain with out_ready=0: in_ready=0 in both modes, and contents hold exactly.
- Full chain with out_ready=1: the chain shifts and accepts a new input the same cycle (no bubble).
- count:
  - Registered; equals popcount of v.
  - Next value = count + in_xfer - out_xfer, or 0 on flush/reset.
  - Never exceeds DEPTH; an assertion checks this.
- The bench checks these invariants every cycle:
  - The out_valid/out_data sequence equals the accepted in_data sequence, in order, with no loss or duplication except flush discards.
  - If out_valid & ~out_ready, then out_valid/out_data are stable next cycle (unless flush or reset).

Test Plan:
1. Reset, then stream 0x11,0x22,0x33,0x44 with out_ready=1, DEPTH=3 -> out_data 0x11 at cycle 3 after first accept, then one value per cycle. count steady at 3, in_ready always 1.
2. COLLAPSE=1 bubble collapse:
   - Setup: accept 0xA0, idle 1 cycle, accept 0xA1; then hold out_ready=0 once 0xA0 reaches the tail.
   - Required: 0xA1 advances into the gap next to 0xA0; a third word is accepted; in_ready drops to 0 only when count=3.
   - COLLAPSE=0 same stimulus: the bubble stays and in_ready=0 as soon as the tail stalls.
3. Full chain (0x1,0x2,0x3), out_ready=0 for 5 cycles -> out_data=0x1 stable, in_ready=0, count=3. Then out_ready=1 with in_valid=1, in_data=0x4 -> accept the same cycle, output order 0x1,0x2,0x3,0x4.
4. Flush with a full chain and out_ready=1 -> 0x1 counted as delivered, in_data that cycle not accepted (in_ready=0). Next cycle: out_valid=0, count=0.
5. Drive reset=0 mid-stream with 2 valid stages and flush=0 -> next cycle out_valid=0, out_data=0, count=0. After reset=1, the first new word emerges after DEPTH cycles.
6. DEPTH=1 and DEPTH=8, random in_valid/out_ready over 2000 cycles -> scoreboard shows in-order, lossless delivery; count matches popcount; count never exceeds DEPTH.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: DEPTH register stages with a valid/ready handshake at both
// ends. With COLLAPSE=1, an upstream stage advances into an empty slot while the
// tail is stalled. With COLLAPSE=0, the whole chain advances or holds together.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous reset, active-low
//   flush      clears every valid bit at the next edge; data registers hold
//   in_valid   producer has data
//   in_data    producer data
//   in_ready   chain accepts in_data this cycle (combinational)
//   out_valid  last stage holds valid data (registered)
//   out_data   last stage data (registered)
//   out_ready  consumer accepts out_data this cycle
//   count      number of valid stages (registered)
module pipe_stage_chain #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned COLLAPSE = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  logic [DEPTH-1:0] load_c;    // stage captures its upstream source this edge
  logic [DEPTH-1:0] src_v_c;
  logic [WIDTH-1:0] src_d_c [DEPTH];
  logic             in_xfer_c;
  logic             out_xfer_c;

  assign in_ready   = load_c[0] & ~flush;
  assign in_xfer_c  = in_valid & in_ready;
  assign out_xfer_c = v_q[DEPTH-1] & out_ready;

  // Per-stage load enable, source select and next state.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (COLLAPSE != 0) begin : g_collapse
      // A stage can load unless it and every stage downstream is full and the tail is stalled.
      assign load_c[g] = ~(&v_q[DEPTH-1:g]) | out_ready;
    end else begin : g_lockstep
      assign load_c[g] = ~v_q[DEPTH-1] | out_ready;
    end

    if (g == 0) begin : g_head
      assign src_v_c[g] = in_xfer_c;
      assign src_d_c[g] = in_data;
    end else begin : g_body
      assign src_v_c[g] = v_q[g-1];
      assign src_d_c[g] = d_q[g-1];
    end

    assign v_d[g] = flush ? 1'b0 : (load_c[g] ? src_v_c[g] : v_q[g]);
    // Data only moves with a valid word so empty slots do not toggle.
    assign d_d[g] = (~flush & load_c[g] & src_v_c[g]) ? src_d_c[g] : d_q[g];
  end

  // Occupancy tracks transfers; a flush empties the chain after any output transfer.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(in_xfer_c) - CW'(out_xfer_c);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q     <= '0;
      d_q     <= '{default: '0};
      count_q <= '0;
    end else begin
      v_q     <= v_d;
      d_q     <= d_d;
      count_q <= count_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign count     = count_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CW'(DEPTH));

  a_count_popcount : assert property (@(posedge clk) disable iff (!reset)
    32'($countones(v_q)) == 32'(count_q));

endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: drives four pipe_stage_chain instances with shared inputs
// (DEPTH3/collapse, DEPTH3/lockstep, DEPTH1/lockstep, DEPTH8/collapse) and
// compares every instance each cycle against an item-level reference model.
// That model is a queue of words, each carrying its distance from the input.
module tb_pipe_stage_chain;

  localparam int unsigned W  = 32;
  localparam int          NI = 4;

  typedef struct {
    logic [W-1:0] data;
    int           pos;
  } item_t;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         exp_ir;
    logic         exp_ov;
    logic [W-1:0] exp_od;
    int           exp_cnt;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic [NI-1:0] in_ready_w, out_valid_w;
  logic [W-1:0]  out_data_w [NI];
  logic [1:0]    cnt_c3, cnt_l3;
  logic [0:0]    cnt_l1;
  logic [3:0]    cnt_c8;

  int checks   = 0;
  int failures = 0;

  item_t mq [NI][$];

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(W), .DEPTH(3), .COLLAPSE(1)) u_c3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_data(out_data_w[0]),
    .out_ready(out_ready), .count(cnt_c3));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(3), .COLLAPSE(0)) u_l3 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_data(out_data_w[1]),
    .out_ready(out_ready), .count(cnt_l3));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(1), .COLLAPSE(0)) u_l1 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[2]), .out_valid(out_valid_w[2]), .out_data(out_data_w[2]),
    .out_ready(out_ready), .count(cnt_l1));

  pipe_stage_chain #(.WIDTH(W), .DEPTH(8), .COLLAPSE(1)) u_c8 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_w[3]), .out_valid(out_valid_w[3]), .out_data(out_data_w[3]),
    .out_ready(out_ready), .count(cnt_c8));

  function automatic int dep(int k);
    case (k)
      0, 1:    return 3;
      2:       return 1;
      default: return 8;
    endcase
  endfunction

  function automatic bit coll(int k);
    return (k == 0) || (k == 3);
  endfunction

  function automatic logic [31:0] cnt(int k);
    case (k)
      0:       return 32'(cnt_c3);
      1:       return 32'(cnt_l3);
      2:       return 32'(cnt_l1);
      default: return 32'(cnt_c8);
    endcase
  endfunction

  // Reference model: the tail word is the oldest one sitting at distance DEPTH-1.
  function automatic bit m_ov(int k);
    return (mq[k].size() > 0) && (mq[k][0].pos == dep(k) - 1);
  endfunction

  function automatic bit m_ir(int k);
    bit r;
    if (coll(k)) r = (mq[k].size() < dep(k)) || out_ready;
    else         r = !m_ov(k) || out_ready;
    return r && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("k%0d in_ready", k), 32'(in_ready_w[k]), 32'(m_ir(k)));
      chk($sformatf("k%0d out_valid", k), 32'(out_valid_w[k]), 32'(m_ov(k)));
      if (m_ov(k)) chk($sformatf("k%0d out_data", k), out_data_w[k], mq[k][0].data);
      chk($sformatf("k%0d count", k), cnt(k), 32'(mq[k].size()));
      chk($sformatf("k%0d count_bound", k), 32'(cnt(k) <= 32'(dep(k))), 32'd1);
    end
  endtask

  // A word moves one place if any slot ahead of it is free or the tail drains
  // (collapse), or if the tail is empty or draining (lockstep).
  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      item_t nq[$];
      bit    ox, ix, adv;
      item_t it;
      if (!reset || flush) begin
        mq[k].delete();
      end else begin
        ox = m_ov(k) && out_ready;
        ix = in_valid && m_ir(k);
        for (int i = 0; i < mq[k].size(); i++) begin
          it = mq[k][i];
          if (!(i == 0 && ox)) begin
            if (coll(k)) adv = out_ready || (i < dep(k) - 1 - it.pos);
            else         adv = !m_ov(k) || out_ready;
            if (adv) it.pos++;
            nq.push_back(it);
          end
        end
        if (ix) begin
          it.data = in_data;
          it.pos  = 0;
          nq.push_back(it);
        end
        mq[k] = nq;
      end
    end
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy,
                       input logic fl = 1'b0, input logic rs = 1'b1);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
  endtask

  task automatic tick();
    model_check();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hchk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    chk($sformatf("k%0d %s", k, name), act, exp);
  endtask

  vec_t tv [8];

  initial begin
    tv[0] = '{1'b1, 32'h11, 1'b1, 1'b1, 1'b0, 32'h0,  0};
    tv[1] = '{1'b1, 32'h22, 1'b1, 1'b1, 1'b0, 32'h0,  1};
    tv[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b0, 32'h0,  2};
    tv[3] = '{1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h11, 3};
    tv[4] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h22, 3};
    tv[5] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h33, 2};
    tv[6] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 32'h44, 1};
    tv[7] = '{1'b0, 32'h0,  1'b1, 1'b1, 1'b0, 32'h0,  0};

    // Power-up reset
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(1'b0, '0, 1'b0);
    for (int k = 0; k < NI; k++) begin
      hchk(k, "rst out_valid", 32'(out_valid_w[k]), 32'd0);
      hchk(k, "rst out_data", out_data_w[k], 32'd0);
      hchk(k, "rst count", cnt(k), 32'd0);
      hchk(k, "rst in_ready", 32'(in_ready_w[k]), 32'd1);
    end
    tick();

    // Streaming table, checked on both DEPTH=3 chains
    for (int r = 0; r < 8; r++) begin
      drive(tv[r].iv, tv[r].id, tv[r].ordy);
      for (int k = 0; k < 2; k++) begin
        hchk(k, $sformatf("tv%0d in_ready", r), 32'(in_ready_w[k]), 32'(tv[r].exp_ir));
        hchk(k, $sformatf("tv%0d out_valid", r), 32'(out_valid_w[k]), 32'(tv[r].exp_ov));
        if (tv[r].exp_ov) hchk(k, $sformatf("tv%0d out_data", r), out_data_w[k], tv[r].exp_od);
        hchk(k, $sformatf("tv%0d count", r), cnt(k), 32'(tv[r].exp_cnt));
      end
      tick();
    end

    // Bubble collapse against lockstep
    drive(1'b1, 32'hA0, 1'b1); tick();
    drive(1'b0, 32'h0,  1'b1); tick();
    drive(1'b1, 32'hA1, 1'b1); tick();
    drive(1'b1, 32'hA2, 1'b0);
    hchk(0, "bub in_ready", 32'(in_ready_w[0]), 32'd1);
    hchk(0, "bub count", cnt(0), 32'd2);
    hchk(0, "bub out_data", out_data_w[0], 32'hA0);
    hchk(1, "bub in_ready", 32'(in_ready_w[1]), 32'd0);
    hchk(1, "bub count", cnt(1), 32'd2);
    tick();
    drive(1'b1, 32'hA3, 1'b0);
    hchk(0, "bub full in_ready", 32'(in_ready_w[0]), 32'd0);
    hchk(0, "bub full count", cnt(0), 32'd3);
    hchk(1, "bub hold count", cnt(1), 32'd2);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    hchk(0, "drain0 out_data", out_data_w[0], 32'hA0);
    hchk(1, "drain0 out_data", out_data_w[1], 32'hA0);
    tick();
    hchk(0, "drain1 out_data", out_data_w[0], 32'hA1);
    hchk(1, "drain1 gap", 32'(out_valid_w[1]), 32'd0);
    tick();
    hchk(0, "drain2 out_data", out_data_w[0], 32'hA2);
    hchk(1, "drain2 out_data", out_data_w[1], 32'hA1);
    repeat (12) tick();

    // Full chain stalled, then shift-and-accept in one cycle
    drive(1'b1, 32'h1, 1'b0); tick();
    drive(1'b1, 32'h2, 1'b0); tick();
    drive(1'b1, 32'h3, 1'b0); tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h4, 1'b0);
      for (int k = 0; k < 2; k++) begin
        hchk(k, "stall out_data", out_data_w[k], 32'h1);
        hchk(k, "stall in_ready", 32'(in_ready_w[k]), 32'd0);
        hchk(k, "stall count", cnt(k), 32'd3);
      end
      tick();
    end
    drive(1'b1, 32'h4, 1'b1);
    hchk(0, "full accept", 32'(in_ready_w[0]), 32'd1);
    hchk(1, "full accept", 32'(in_ready_w[1]), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    hchk(0, "order 2", out_data_w[0], 32'h2);
    hchk(0, "order count", cnt(0), 32'd3);
    tick();
    hchk(1, "order 3", out_data_w[1], 32'h3);
    tick();
    hchk(0, "order 4", out_data_w[0], 32'h4);
    repeat (12) tick();

    // Flush on a full chain with the consumer ready
    drive(1'b1, 32'h1, 1'b0); tick();
    drive(1'b1, 32'h2, 1'b0); tick();
    drive(1'b1, 32'h3, 1'b0); tick();
    drive(1'b1, 32'h9, 1'b1, 1'b1);
    hchk(0, "flush in_ready", 32'(in_ready_w[0]), 32'd0);
    hchk(1, "flush in_ready", 32'(in_ready_w[1]), 32'd0);
    hchk(0, "flush delivered", out_data_w[0], 32'h1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      hchk(k, "post flush out_valid", 32'(out_valid_w[k]), 32'd0);
      hchk(k, "post flush count", cnt(k), 32'd0);
    end
    tick();

    // Reset mid-stream with two valid stages
    drive(1'b1, 32'hB0, 1'b0); tick();
    drive(1'b1, 32'hB1, 1'b0); tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC0, 1'b1);
    for (int k = 0; k < NI; k++) begin
      hchk(k, "mid rst out_valid", 32'(out_valid_w[k]), 32'd0);
      hchk(k, "mid rst out_data", out_data_w[k], 32'd0);
      hchk(k, "mid rst count", cnt(k), 32'd0);
    end
    tick();
    drive(1'b0, 32'h0, 1'b1);
    hchk(0, "lat c1", 32'(out_valid_w[0]), 32'd0);
    hchk(2, "lat d1", out_data_w[2], 32'hC0);
    tick();
    hchk(0, "lat c2", 32'(out_valid_w[0]), 32'd0);
    tick();
    hchk(0, "lat c3 valid", 32'(out_valid_w[0]), 32'd1);
    hchk(0, "lat c3 data", out_data_w[0], 32'hC0);
    repeat (10) tick();

    // Randomised traffic with occasional flush and reset
    for (int c = 0; c < 2000; c++) begin
      int unsigned ordy_pct;
      ordy_pct = ((c / 250) % 2 == 0) ? 70 : 30;
      drive(($urandom % 100) < 65, $urandom, ($urandom % 100) < ordy_pct,
            ($urandom % 64) == 0, ($urandom % 250) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
